// File: rtl/sysu_sar_cmp_ctrl.sv
// Successive-approximation controller that binary-searches the A port of an external cascadable comparator.
// Optional build macro SAR_EARLY_EXIT_EN: an equality answer ends the search at that step.
module sysu_sar_cmp_ctrl #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic             CLK,
    input  logic             nCLR,
    input  logic             START,
    input  logic             QAgB,
    input  logic             QAeB,
    input  logic             QAlB,
    output logic [WIDTH-1:0] B,
    output logic             OIAgB,
    output logic             OIAeB,
    output logic             OIAlB,
    output logic [WIDTH-1:0] RESULT,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic [1:0]       dbg_state_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_TRIAL = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = $clog2(SETTLE + 1);
    localparam logic [IW-1:0] IDX_MSB    = IW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_SETTLE = CW'(SETTLE);

    logic [1:0]       state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] res_new;
    logic [2:0]       code;
    logic             finish;

    // Handshake: START is a level sampled only in IDLE/DONE; BUSY covers the
    // whole search and DONE (with RESULT/ERR) holds until the next accepted START.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        b_d      = b_q;
        res_d    = res_q;
        busy_d   = busy_q;
        done_d   = done_q;
        err_d    = err_q;
        bit_mask = WIDTH'(1) << idx_q;
        code     = {QAgB, QAeB, QAlB};
        res_new  = res_q;
        finish   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (START) begin
                    res_d   = '0;
                    err_d   = 1'b0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    idx_d   = IDX_MSB;
                    b_d     = WIDTH'(1) << IDX_MSB;
                    cnt_d   = CW'(1);
                    state_d = S_TRIAL;
                end
            end
            S_TRIAL: begin
                if (cnt_q != CNT_SETTLE) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    case (code)
                        3'b100: res_new = res_q | bit_mask;
                        3'b001: res_new = res_q & ~bit_mask;
                        3'b010: begin
                            res_new = res_q | bit_mask;
`ifdef SAR_EARLY_EXIT_EN
                            finish  = 1'b1;
`endif
                        end
                        default: begin
                            // Bit under test is not trusted: leave it clear and stop.
                            res_new = res_q & ~bit_mask;
                            err_d   = 1'b1;
                            finish  = 1'b1;
                        end
                    endcase
                    if (idx_q == '0) begin
                        finish = 1'b1;
                    end
                    res_d = res_new;
                    if (finish) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        b_d     = res_new;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q - IW'(1);
                        b_d   = res_new | (bit_mask >> 1);
                        cnt_d = CW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            b_q     <= '0;
            res_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            b_q     <= b_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Cascade inputs 0/1/0 make a chained comparator report true equality on ties.
    assign OIAgB       = 1'b0;
    assign OIAeB       = 1'b1;
    assign OIAlB       = 1'b0;
    assign B           = b_q;
    assign RESULT      = res_q;
    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign ERR         = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sysu_sar_cmp_ctrl.sv
// Directed bench for sysu_sar_cmp_ctrl: a SETTLE=1 and a SETTLE=3 instance, each searching a behavioural comparator.
module tb_sysu_sar_cmp_ctrl;

    logic CLK = 1'b0;
    logic nCLR;
    int   checks   = 0;
    int   failures = 0;

    // Instance 0: WIDTH=4, SETTLE=1
    logic       start0;
    logic [3:0] a0;
    logic       force0_en;
    logic [2:0] force0_code;
    logic       gt0, eq0, lt0;
    logic [3:0] b0, res0;
    logic       oig0, oie0, oil0, busy0, done0, err0;
    logic [1:0] st0;

    // Instance 1: WIDTH=4, SETTLE=3
    logic       start1;
    logic [3:0] a1;
    logic       gt1, eq1, lt1;
    logic [3:0] b1, res1;
    logic       oig1, oie1, oil1, busy1, done1, err1;
    logic [1:0] st1;

    always #5 CLK = ~CLK;

    assign {gt0, eq0, lt0} = force0_en ? force0_code : {a0 > b0, a0 == b0, a0 < b0};
    assign {gt1, eq1, lt1} = {a1 > b1, a1 == b1, a1 < b1};

    sysu_sar_cmp_ctrl #(.WIDTH(4), .SETTLE(1)) dut0 (
        .CLK(CLK), .nCLR(nCLR), .START(start0),
        .QAgB(gt0), .QAeB(eq0), .QAlB(lt0),
        .B(b0), .OIAgB(oig0), .OIAeB(oie0), .OIAlB(oil0),
        .RESULT(res0), .BUSY(busy0), .DONE(done0), .ERR(err0),
        .dbg_state_o(st0)
    );

    sysu_sar_cmp_ctrl #(.WIDTH(4), .SETTLE(3)) dut1 (
        .CLK(CLK), .nCLR(nCLR), .START(start1),
        .QAgB(gt1), .QAeB(eq1), .QAlB(lt1),
        .B(b1), .OIAgB(oig1), .OIAeB(oie1), .OIAlB(oil1),
        .RESULT(res1), .BUSY(busy1), .DONE(done1), .ERR(err1),
        .dbg_state_o(st1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Runs one search on instance 0. trials holds the expected B values, MSB
    // nibble first; START is re-pulsed before edge k+pulse+1 (pulse<0: never).
    task automatic search0(input string tag, input logic [3:0] a, input logic [15:0] trials,
                           input int lat, input logic [3:0] res, input int pulse);
        a0 = a;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int j = 0; j < lat; j++) begin
            check({tag, "_busy"}, busy0, 1);
            check({tag, "_done_early"}, done0, 0);
            check({tag, "_err"}, err0, 0);
            check({tag, "_trial"}, b0, trials[15-4*j -: 4]);
            start0 = (j == pulse);
            tick();
            start0 = 1'b0;
        end
        check({tag, "_done"}, done0, 1);
        check({tag, "_busy_end"}, busy0, 0);
        check({tag, "_result"}, res0, res);
        check({tag, "_b_final"}, b0, res);
        check({tag, "_state"}, st0, 2);
        tick();
        check({tag, "_done_held"}, done0, 1);
    endtask

    initial begin
        nCLR        = 1'b0;
        start0      = 1'b0;
        start1      = 1'b0;
        a0          = 4'h0;
        a1          = 4'h0;
        force0_en   = 1'b0;
        force0_code = 3'b000;
        #1;
        check("rst_b", b0, 0);
        check("rst_result", res0, 0);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_err", err0, 0);
        check("rst_state", st0, 0);
        check("cascade", {oig0, oie0, oil0}, 3'b010);
        check("rst_b1", b1, 0);
        #20;
        @(negedge CLK);
        nCLR = 1'b1;
        tick();
        check("idle_hold", st0, 0);

`ifdef SAR_EARLY_EXIT_EN
        search0("a_c", 4'hC, 16'h8C00, 2, 4'hC, -1);
        search0("a_a", 4'hA, 16'h8CA0, 3, 4'hA, -1);
        search0("busy_start", 4'h6, 16'h8460, 3, 4'h6, 1);
`else
        search0("a_c", 4'hC, 16'h8CED, 4, 4'hC, -1);
        search0("a_a", 4'hA, 16'h8CAB, 4, 4'hA, -1);
        search0("busy_start", 4'h6, 16'h8467, 4, 4'h6, 1);
`endif
        search0("a_0", 4'h0, 16'h8421, 4, 4'h0, -1);
        search0("a_f", 4'hF, 16'h8CEF, 4, 4'hF, -1);
        search0("end_start", 4'h5, 16'h8465, 4, 4'h5, 3);

        // Illegal code 000 on the very first sample.
        force0_en   = 1'b1;
        force0_code = 3'b000;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("err0_trial", b0, 4'h8);
        tick();
        check("err0_err", err0, 1);
        check("err0_done", done0, 1);
        check("err0_busy", busy0, 0);
        check("err0_result", res0, 0);
        force0_en = 1'b0;
        search0("after_err", 4'h3, 16'h8423, 4, 4'h3, -1);

        // Illegal code 011 on the second sample: the kept MSB survives.
        a0 = 4'hC;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        check("err2_trial", b0, 4'hC);
        force0_en   = 1'b1;
        force0_code = 3'b011;
        tick();
        check("err2_err", err0, 1);
        check("err2_done", done0, 1);
        check("err2_result", res0, 4'h8);
        check("err2_b", b0, 4'h8);
        force0_en = 1'b0;

        // Asynchronous reset after edge k+2 of a search.
        a0 = 4'h0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        tick();
        check("mid_busy", busy0, 1);
        nCLR = 1'b0;
        #1;
        check("mid_rst_b", b0, 0);
        check("mid_rst_result", res0, 0);
        check("mid_rst_busy", busy0, 0);
        check("mid_rst_done", done0, 0);
        check("mid_rst_err", err0, 0);
        check("mid_rst_state", st0, 0);
        @(negedge CLK);
        nCLR = 1'b1;
        tick();
        check("post_rst_state", st0, 0);
        check("post_rst_busy", busy0, 0);

        // SETTLE=3: each trial held three cycles.
        a1 = 4'h5;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int j = 0; j < 4; j++) begin
            logic [15:0] tr;
            tr = 16'h8465;
            for (int c = 0; c < 3; c++) begin
                check("s3_trial", b1, tr[15-4*j -: 4]);
                check("s3_done_early", done1, 0);
                tick();
            end
        end
        check("s3_done", done1, 1);
        check("s3_busy", busy1, 0);
        check("s3_result", res1, 4'h5);
        check("s3_err", err1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sysu_sar_cmp_ctrl.md
Name: sysu_sar_cmp_ctrl

Overview:
- Successive-approximation controller: the driving end of a magnitude-comparator interface.
- Drives the trial word B and the cascade inputs of an external comparator (74LS85-style, cascadable to WIDTH bits) whose A port carries an unknown value.
- Reads the QAgB/QAeB/QAlB answers back, one bit per step, and binary-searches A; the final RESULT equals A.
- Sits beside comparator-based test fixtures and threshold/ADC-style datapaths.

Parameters:
- WIDTH, 4: bits searched; valid range 1..16.
- SETTLE, 1: cycles each trial is held before the compare outputs are sampled; must be >= 1.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- nCLR  input  1  asynchronous active-low reset.
- START  input  1  begin a search; sampled only in IDLE or DONE.
- QAgB  input  1  comparator A>B.
- QAeB  input  1  comparator A=B.
- QAlB  input  1  comparator A<B.
- B  output  WIDTH  trial word to comparator B port.
- OIAgB  output  1  cascade input to comparator; constant 0.
- OIAeB  output  1  cascade input to comparator; constant 1.
- OIAlB  output  1  cascade input to comparator; constant 0.
- RESULT  output  WIDTH  search result / partial result.
- BUSY  output  1  search in progress.
- DONE  output  1  search finished; held until next START.
- ERR  output  1  illegal compare code seen in last search.

Behaviour:
- Clocking and reset: single clock CLK; reset nCLR is asynchronous, active-low.
- Reset values: B=0, RESULT=0, BUSY=0, DONE=0, ERR=0, state=IDLE, settle counter=0. Reset asserted mid-search aborts immediately, with no partial completion.
- Cascade outputs are constant 0/1/0, so a cascaded comparator reports true equality on ties.
- States: IDLE, TRIAL, DONE.
- IDLE/DONE, START=1 at edge k:
  - RESULT<=0, ERR<=0, DONE<=0, BUSY<=1.
  - bit index i<=WIDTH-1, B<=1<<(WIDTH-1), counter<=1, go to TRIAL.
- TRIAL, counter<SETTLE: counter++, B held.
- TRIAL, counter==SETTLE: sample {QAgB,QAeB,QAlB}:
  - 100: RESULT[i]<=1 (A > trial; keep bit).
  - 001: RESULT[i]<=0 (clear bit).
  - 010: RESULT[i]<=1; early-exit rule per Optional Feature.
  - Any other code (000, 011, 110, 111, 101): ERR<=1, RESULT keeps bits decided so far (bit i = 0), go to DONE.
  - If i==0 or exit: BUSY<=0, DONE<=1, B<=final RESULT, go to DONE.
  - Else: i--, B<=RESULT_new | (1<<(i-1)), counter<=1.
- Latency: a full search asserts DONE at edge k+WIDTH*SETTLE. An equality exit at step j (j=1 is the MSB step) asserts DONE at edge k+j*SETTLE.
- START while BUSY is ignored.
- START held high in DONE restarts on the next edge.
- START in the same edge that completes a search is ignored; the search completes to DONE.
- Comparator inputs are ignored outside the sample edge.
- Arithmetic is unsigned; RESULT range is 0..2^WIDTH-1.
  - A=0: all trials answer 001, giving RESULT=0.
  - A=max: final trial is all-ones and answers 010.

Optional Feature:
- Macro: SAR_EARLY_EXIT_EN.
- Defined: a 010 answer ends the search at that step (DONE, RESULT = current trial, lower bits 0).
- Undefined: 010 is treated as 100 (keep bit) and the search always runs all WIDTH steps; the result is identical, only latency differs.

Test Plan:
- WIDTH=4, SETTLE=1, behavioural comparator A=0xC, START at edge k:
  - Trials 0x8 -> 0xC.
  - With macro: DONE at k+2, RESULT=0xC.
  - Without macro: trials 0x8, 0xC, 0xE, 0xD; DONE at k+4, RESULT=0xC.
- A=0x0: trials 0x8, 0x4, 0x2, 0x1 all answer 001 -> RESULT=0x0, DONE at k+4, ERR=0.
- A=0xF: trials 0x8, 0xC, 0xE, 0xF; last answers 010 -> RESULT=0xF, B=0xF after DONE.
- Force code 000 on the first sample -> ERR=1, DONE=1, BUSY=0, RESULT=0x0 at k+1; next START clears ERR.
- Control cases:
  - nCLR low mid-search (after edge k+2) -> all outputs 0 immediately, state IDLE.
  - Pulse START while BUSY=1 -> no restart, trial sequence unchanged.
- SETTLE=3, A=0x5: each B value held 3 cycles; trials 0x8, 0x4, 0x6, 0x5 -> DONE at k+12, RESULT=0x5.
